// File: rtl/math_pkg.sv
// Shared math definitions: booth codec variants, arbiter helper, pipeline latency.
package math_pkg;

  typedef enum logic [1:0] {
    MBE_I,
    MBE_II,
    MBE_III,
    MBE_IV
  } mbe_e;

  // Request-handshake edge to response-valid sample edge.
  localparam int MULT_ARB_LAT = 2;

  // One-hot grant for the first set bit of req searching upward from ptr+1,
  // wrapping at n-1 back to 0. Supports up to 32 requesters.
  function automatic logic [31:0] rr_next(input logic [31:0] req, input int ptr, input int n);
    logic [31:0] gnt;
    logic        found;
    int          idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[4:0]]) begin
          gnt[idx[4:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mult_bw.sv
// Radix-4 modified-booth multiplier, purely combinational, signed or unsigned per operation.
module mult_bw
  import math_pkg::*;
#(
  parameter int   ADw = 8,
  parameter int   BDw = 8,
  parameter mbe_e MBE = MBE_IV,
  parameter int   CDw = ADw + BDw
) (
  input  logic           tc_mode_i,
  input  logic [ADw-1:0] a_i,
  input  logic [BDw-1:0] b_i,
  output logic [CDw-1:0] c_o
);

  // b is widened by at least one extension bit so unsigned operands recode correctly,
  // and rounded up to an even width so it splits into whole booth digits.
  localparam int BW = BDw + 2 + (BDw % 2);
  localparam int ND = BW / 2;

  logic [CDw-1:0] a_ext;
  logic [BW:0]    b_ext;
  logic [2:0]     trip;
  logic [CDw-1:0] mag;
  logic [CDw-1:0] pp;
  logic           neg;
  logic [CDw-1:0] acc;

  // Recode b into booth digits, form each partial product from a and sum them modulo 2^CDw.
  always_comb begin
    a_ext = {{BDw{tc_mode_i & a_i[ADw-1]}}, a_i};
    b_ext = {{(BW - BDw){tc_mode_i & b_i[BDw-1]}}, b_i, 1'b0};
    acc   = '0;
    trip  = '0;
    mag   = '0;
    pp    = '0;
    neg   = 1'b0;
    for (int i = 0; i < ND; i++) begin
      trip = b_ext[2*i +: 3];
      neg  = trip[2] & ~(trip[1] & trip[0]);
      if (trip == 3'b000 || trip == 3'b111) begin
        mag = '0;
      end else if (trip == 3'b011 || trip == 3'b100) begin
        mag = a_ext << 1;
      end else begin
        mag = a_ext;
      end
      // The codec variants differ only in how a negative digit is formed.
      if (MBE == MBE_I) begin
        pp = neg ? (~mag + CDw'(1)) : mag;
      end else begin
        pp = (mag ^ {CDw{neg}}) + CDw'(neg);
      end
      acc = acc + (pp << (2 * i));
    end
    c_o = acc;
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: combinational grant, pointer remembers the last accepted requester.
module rr_arb
  import math_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] ptr;
  logic [N-1:0]  gnt_raw;

  // Pick the next requester after the pointer and encode its index.
  always_comb begin
    gnt_raw = N'(rr_next(32'(req), int'(ptr), N));
    gnt     = gnt_raw & {N{en}};
    gnt_id  = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) gnt_id = IW'(k);
    end
  end

  // Pointer moves only on an accepted grant; starts at N-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IW'(N - 1);
    end else if (|gnt) begin
      ptr <= gnt_id;
    end
  end

endmodule

// File: rtl/mult_arb.sv
// Shares one booth multiplier among NREQ requesters through a two-stage pipeline.
module mult_arb
  import math_pkg::*;
#(
  parameter int   NREQ = 4,
  parameter int   ADw  = 8,
  parameter int   BDw  = 8,
  parameter mbe_e MBE  = MBE_IV,
  parameter int   IDw  = $clog2(NREQ),
  parameter int   CDw  = ADw + BDw
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ-1:0]   tc_mode_i,
  input  logic [NREQ*ADw-1:0] a_i,
  input  logic [NREQ*BDw-1:0] b_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDw-1:0]    rsp_id_o,
  output logic [CDw-1:0]    rsp_c_o,
  output logic              busy_o
);

  logic            s1_vld, s2_vld;
  logic            s1_en, s2_en;
  logic [IDw-1:0]  s1_id, s2_id;
  logic            s1_tc;
  logic [ADw-1:0]  s1_a, sel_a;
  logic [BDw-1:0]  s1_b, sel_b;
  logic            sel_tc;
  logic [CDw-1:0]  s2_c, mult_c;
  logic [NREQ-1:0] gnt;
  logic [IDw-1:0]  gnt_id;
  logic            hs;

  // Enables depend only on pipeline state and rsp_ready_i, never on request valids.
  assign s2_en = ~s2_vld | rsp_ready_i;
  assign s1_en = ~s1_vld | s2_en;

  rr_arb #(.N(NREQ), .IW(IDw)) u_arb (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .req    (req_valid_i),
    .en     (s1_en & rst_ni),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready_o = gnt;
  assign hs          = |gnt;

  // Route the granted requester's operands towards stage 1.
  always_comb begin
    sel_a  = a_i[gnt_id*ADw +: ADw];
    sel_b  = b_i[gnt_id*BDw +: BDw];
    sel_tc = tc_mode_i[gnt_id];
  end

  // Stage 1 operand register: refills whenever it can advance; captures only on a handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld <= 1'b0;
      s1_id  <= '0;
      s1_tc  <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (s1_en) begin
      s1_vld <= hs;
      if (hs) begin
        s1_id <= gnt_id;
        s1_tc <= sel_tc;
        s1_a  <= sel_a;
        s1_b  <= sel_b;
      end
    end
  end

  mult_bw #(.ADw(ADw), .BDw(BDw), .MBE(MBE), .CDw(CDw)) u_mult (
    .tc_mode_i (s1_tc),
    .a_i       (s1_a),
    .b_i       (s1_b),
    .c_o       (mult_c)
  );

  // Stage 2 result register: advances when empty or its content is being taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_vld <= 1'b0;
      s2_id  <= '0;
      s2_c   <= '0;
    end else if (s2_en) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_id <= s1_id;
        s2_c  <= mult_c;
      end
    end
  end

  assign rsp_valid_o = s2_vld;
  assign rsp_id_o    = s2_id;
  assign rsp_c_o     = s2_c;
  assign busy_o      = s1_vld | s2_vld;

endmodule

// File: tb/tb_mult_arb.sv
// Randomized bench for mult_arb against a transaction-level reference model.
module tb_mult_arb;
  import math_pkg::*;

  localparam int NREQ = 4;
  localparam int ADw  = 8;
  localparam int BDw  = 8;
  localparam int IDw  = 2;
  localparam int CDw  = 16;

  logic                clk_i;
  logic                rst_ni;
  logic [NREQ-1:0]     req_valid_i;
  logic [NREQ-1:0]     req_ready_o;
  logic [NREQ-1:0]     tc_mode_i;
  logic [NREQ*ADw-1:0] a_i;
  logic [NREQ*BDw-1:0] b_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [IDw-1:0]      rsp_id_o;
  logic [CDw-1:0]      rsp_c_o;
  logic                busy_o;

  mult_arb #(.NREQ(NREQ), .ADw(ADw), .BDw(BDw), .MBE(MBE_IV)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .tc_mode_i   (tc_mode_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_c_o     (rsp_c_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic [15:0] c;
    int          t;
  } txn_t;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: accepted-but-unanswered products in order, last granted id.
  txn_t        q[$];
  int          ptr_m;
  int          cyc;
  int          n_acc, n_rsp;
  int          last_id, last_push_cyc, last_pop_cyc;
  logic [15:0] last_c;

  // Requester behaviour: a raised request stays put until accepted.
  logic        pend_v  [NREQ];
  logic        pend_tc [NREQ];
  logic [7:0]  pend_a  [NREQ];
  logic [7:0]  pend_b  [NREQ];
  logic [NREQ-1:0] active;
  int          p_new, p_rdy;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_product(input logic tc, input logic [7:0] a, input logic [7:0] b);
    int x, y;
    if (tc) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    return 16'(x * y);
  endfunction

  // One clock cycle: drive at the falling edge, check just after, update the model at the rising edge.
  task automatic applyStimulus();
    int   win, hs_k, idx;
    logic rsp_hs, exp_any, exp_rv;
    @(negedge clk_i);
    for (int k = 0; k < NREQ; k++) begin
      if (active[k] && !pend_v[k] && ($urandom_range(0, 99) < p_new)) begin
        pend_v[k]  = 1'b1;
        pend_tc[k] = 1'($urandom_range(0, 1));
        pend_a[k]  = 8'($urandom);
        pend_b[k]  = 8'($urandom);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      req_valid_i[k]       = pend_v[k];
      tc_mode_i[k]         = pend_tc[k];
      a_i[k*ADw +: ADw]    = pend_a[k];
      b_i[k*BDw +: BDw]    = pend_b[k];
    end
    rsp_ready_i = ($urandom_range(0, 99) < p_rdy);
    #1;
    exp_any = (|req_valid_i) && ((q.size() < 2) || rsp_ready_i);
    checkOutput("ready_any", 32'(|req_ready_o), 32'(exp_any));
    checkOutput("ready_onehot", 32'($onehot0(req_ready_o)), 32'd1);
    if (req_ready_o != '0) begin
      win = -1;
      for (int s = 1; s <= NREQ; s++) begin
        idx = (ptr_m + s) % NREQ;
        if (req_valid_i[idx] && win < 0) win = idx;
      end
      checkOutput("grant", 32'(req_ready_o), (win < 0) ? 32'd0 : (32'd1 << win));
    end
    exp_rv = (q.size() > 0) && (cyc >= q[0].t + 1);
    checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
    checkOutput("busy", 32'(busy_o), 32'(q.size() > 0));
    if (rsp_valid_o && q.size() > 0) begin
      checkOutput("rsp_id", 32'(rsp_id_o), 32'(q[0].id));
      checkOutput("rsp_c", 32'(rsp_c_o), 32'(q[0].c));
    end
    hs_k = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_ready_o[k] && req_valid_i[k]) hs_k = k;
    end
    rsp_hs = rsp_valid_o & rsp_ready_i;
    @(posedge clk_i);
    cyc++;
    if (rsp_hs && q.size() > 0) begin
      last_id      = q[0].id;
      last_c       = q[0].c;
      last_pop_cyc = cyc;
      n_rsp++;
      void'(q.pop_front());
    end
    if (hs_k >= 0) begin
      q.push_back('{hs_k, ref_product(pend_tc[hs_k], pend_a[hs_k], pend_b[hs_k]), cyc});
      ptr_m         = hs_k;
      pend_v[hs_k]  = 1'b0;
      last_push_cyc = cyc;
      n_acc++;
    end
  endtask

  task automatic runDirected(input int id, input logic tc, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp_c, input string tag);
    active      = '0;
    p_rdy       = 100;
    pend_v[id]  = 1'b1;
    pend_tc[id] = tc;
    pend_a[id]  = a;
    pend_b[id]  = b;
    for (int n = 0; n < 20 && (pend_v[id] || q.size() > 0); n++) applyStimulus();
    if (pend_v[id] || q.size() > 0) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
    checkOutput({tag, "_id"}, 32'(last_id), 32'(id));
    checkOutput({tag, "_c"}, 32'(last_c), 32'(exp_c));
    checkOutput({tag, "_lat"}, 32'(last_pop_cyc - last_push_cyc), 32'(MULT_ARB_LAT));
  endtask

  task automatic releaseReset();
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rsp_before;
    ptr_m = NREQ - 1;
    cyc = 0; n_acc = 0; n_rsp = 0;
    last_id = -1; last_c = '0; last_push_cyc = 0; last_pop_cyc = 0;
    active = '0; p_new = 0; p_rdy = 100;
    for (int k = 0; k < NREQ; k++) begin
      pend_v[k]  = 1'b1;
      pend_tc[k] = 1'b0;
      pend_a[k]  = 8'(k + 1);
      pend_b[k]  = 8'(k + 3);
    end

    // Reset with every requester asking: nothing may be granted.
    rst_ni      = 1'b0;
    req_valid_i = '1;
    tc_mode_i   = '0;
    a_i         = '0;
    b_i         = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("reset_ready", 32'(req_ready_o), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id_o), 32'd0);
    checkOutput("reset_rsp_c", 32'(rsp_c_o), 32'd0);
    releaseReset();
    applyStimulus();
    checkOutput("first_grant", 32'(last_id < 0 ? ptr_m : ptr_m), 32'd0);
    repeat (8) applyStimulus();

    // Directed products, unsigned and signed.
    runDirected(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "single");
    runDirected(2, 1'b1, 8'h80, 8'h80, 16'h4000, "signed_min");
    runDirected(2, 1'b1, 8'hFF, 8'h02, 16'hFFFE, "signed_neg");

    // Fairness: everyone always asking, downstream always ready.
    active = '1; p_new = 100; p_rdy = 100;
    rsp_before = n_rsp;
    repeat (40) applyStimulus();
    checkOutput("fair_rate", 32'(n_rsp - rsp_before), 32'd38);

    // Backpressure: single streaming requester, random downstream stalls.
    active = '0; p_rdy = 100;
    for (int n = 0; n < 20 && (q.size() > 0 || pend_v[0] || pend_v[1] || pend_v[2] || pend_v[3]); n++)
      applyStimulus();
    active = 4'b0001; p_new = 100; p_rdy = 50;
    repeat (300) applyStimulus();
    active = '0; p_rdy = 100;
    for (int n = 0; n < 20 && (q.size() > 0 || pend_v[0]); n++) applyStimulus();
    checkOutput("drain_empty", 32'(q.size()), 32'd0);
    checkOutput("no_loss", 32'(n_rsp), 32'(n_acc));

    // Reset with both stages full and stalled.
    active = '1; p_new = 100; p_rdy = 0;
    repeat (5) applyStimulus();
    checkOutput("full_busy", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    checkOutput("midrst_ready", 32'(req_ready_o), 32'd0);
    q.delete();
    ptr_m = NREQ - 1;
    active = '0; p_rdy = 100;
    for (int k = 0; k < NREQ; k++) pend_v[k] = 1'b0;
    releaseReset();
    repeat (10) applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
